// File: rtl/uart_pkg.sv
// Shared types for the UART blocks: transmitter state encoding, the per-frame
// configuration snapshot, and the default bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned CFG_DIV_WIDTH = 32;

  typedef struct packed {
    logic [CFG_DIV_WIDTH-1:0] div;
    logic                     parity_en;
    logic                     parity_odd;
    logic                     stop2;
  } frame_cfg_t;

  function automatic int unsigned default_div(input int unsigned clock_freq,
                                              input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally. A full FIFO refuses a push even when popped.
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: the storage array is deliberately not reset; validity is defined by
  // the pointers and count, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-fed, runtime divisor/parity/stop bits,
// back-to-back LSB-first frames with a registered, glitch-free line output.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DEFAULT_DIV = default_div(CLOCK_FREQ, BAUD_RATE);

  tx_state_t             state_q, state_d;
  logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  frame_cfg_t            cfg_q, cfg_d;
  logic                  parity_q, parity_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  serial_q, serial_d;

  logic                  pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  bit_done;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (data_in_valid),
    .wdata_i (data_in),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign data_in_ready = !fifo_full;
  assign busy          = (state_q != IDLE) || !fifo_empty;
  assign serial_out    = serial_q;
  assign bit_done      = (CFG_DIV_WIDTH'(baud_cnt_q) == cfg_q.div - 1'b1);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    cfg_d      = cfg_q;
    parity_d   = parity_q;
    stop_cnt_d = stop_cnt_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        pop        = !fifo_empty;
      end
      START: begin
        if (bit_done) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
            state_d    = cfg_q.parity_en ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          baud_cnt_d = '0;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (cfg_q.stop2 && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            pop = !fifo_empty;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop from IDLE or from the final stop clock starts the next frame with
    // zero gap; configuration is frozen here for the whole frame.
    if (pop) begin
      state_d          = START;
      baud_cnt_d       = '0;
      shift_d          = fifo_rdata;
      parity_d         = ^fifo_rdata;
      cfg_d.div        = (baud_div != '0) ? CFG_DIV_WIDTH'(baud_div)
                                          : CFG_DIV_WIDTH'(DEFAULT_DIV);
      cfg_d.parity_en  = parity_en;
      cfg_d.parity_odd = parity_odd;
      cfg_d.stop2      = stop2;
    end

    unique case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = parity_d ^ cfg_d.parity_odd;
      default: serial_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      cfg_q      <= '{div: CFG_DIV_WIDTH'(DEFAULT_DIV), parity_en: 1'b0,
                      parity_odd: 1'b0, stop2: 1'b0};
      parity_q   <= 1'b0;
      stop_cnt_q <= 1'b0;
      serial_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      cfg_q      <= cfg_d;
      parity_q   <= parity_d;
      stop_cnt_q <= stop_cnt_d;
      serial_q   <= serial_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a queue-based line-level model checked every cycle,
// plus hand-computed frame decodes, lengths and gaps.
module tb_uart_tx_cfg;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop2;
  logic        serial_out, busy;
  logic [2:0]  fifo_count;

  uart_tx_cfg #(
    .CLOCK_FREQ (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .DATA_WIDTH (8),
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .baud_div      (baud_div),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .stop2         (stop2),
    .serial_out    (serial_out),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: bytes waiting, and the line levels still to be driven, one per clock.
  logic [7:0] mfifo[$];
  logic       wave[$];
  logic       exp_out  = 1'b1;
  logic       exp_busy = 1'b0;

  function automatic void build_frame(input logic [7:0] b);
    int   p;
    logic lv[$];
    p = (baud_div != 0) ? int'(baud_div) : CLK_HZ / BAUD;
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
    if (parity_en) lv.push_back((^b) ^ parity_odd);
    lv.push_back(1'b1);
    if (stop2) lv.push_back(1'b1);
    foreach (lv[k]) repeat (p) wave.push_back(lv[k]);
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic accept, in_frame;
    if (reset) begin
      mfifo.delete();
      wave.delete();
      exp_out  = 1'b1;
      exp_busy = 1'b0;
    end else begin
      accept = data_in_valid && (mfifo.size() < DEPTH);
      if (wave.size() == 0 && mfifo.size() != 0) build_frame(mfifo.pop_front());
      in_frame = (wave.size() != 0);
      exp_out  = in_frame ? wave.pop_front() : 1'b1;
      if (accept) mfifo.push_back(data_in);
      exp_busy = in_frame || (mfifo.size() != 0);
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("cyc_serial_out", serial_out, exp_out);
      check("cyc_busy", busy, exp_busy);
      check("cyc_fifo_count", fifo_count, mfifo.size());
      check("cyc_ready", data_in_ready, mfifo.size() < DEPTH);
    end
  end

  // Per-clock log of outputs for the literal frame decodes.
  logic       log_en = 1'b0;
  logic       line_log[$];
  logic       busy_log[$];
  logic [2:0] cnt_log[$];
  logic       rdy_log[$];

  always @(negedge clk) begin
    if (log_en) begin
      line_log.push_back(serial_out);
      busy_log.push_back(busy);
      cnt_log.push_back(fifo_count);
      rdy_log.push_back(data_in_ready);
    end
  end

  task automatic log_start();
    line_log.delete(); busy_log.delete(); cnt_log.delete(); rdy_log.delete();
    log_en = 1'b1;
  endtask

  function automatic logic log_at(input int idx);
    if (idx >= 0 && idx < line_log.size()) return line_log[idx];
    return 1'bx;
  endfunction

  function automatic int first_low();
    foreach (line_log[k]) if (line_log[k] == 1'b0) return k;
    return -1;
  endfunction

  function automatic int busy_run(input int s);
    int n = 0;
    if (s < 0) return -1;
    for (int k = s; k < busy_log.size(); k++) begin
      if (!busy_log[k]) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] decode_byte(input int s, input int p);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = log_at(s + (1 + i) * p + p / 2);
    return b;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    data_in = b;
    data_in_valid = 1'b1;
    while (!data_in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("push_timeout", 0, 1);
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check({name, "_idle_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
    log_en = 1'b0;
  endtask

  task automatic wait_low(input string name);
    int t = 0;
    while (serial_out !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check({name, "_start_timeout"}, 0, 1);
  endtask

  int         s;
  logic [9:0] v;
  int         full_seen, rdy_at_full;

  initial begin
    reset = 1'b1;
    data_in = '0; data_in_valid = 1'b0;
    baud_div = 16'd4; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_serial_out", serial_out, 1);
    check("rst_ready", data_in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // 0x55, 8N1, P=4
    log_start();
    push_byte(8'h55);
    wait_idle("t1");
    s = first_low();
    for (int i = 0; i < 10; i++) v[i] = log_at(s + i * 4 + 2);
    check("t1_bits_0x55", v, 10'b1010101010);
    check("t1_frame_len", busy_run(s), 40);

    // 0x07 with even then odd parity
    parity_en = 1'b1;
    log_start();
    push_byte(8'h07);
    wait_idle("t2e");
    s = first_low();
    check("t2_even_data", decode_byte(s, 4), 8'h07);
    check("t2_even_parity", log_at(s + 9 * 4 + 2), 1);
    check("t2_even_len", busy_run(s), 44);
    parity_odd = 1'b1;
    log_start();
    push_byte(8'h07);
    wait_idle("t2o");
    s = first_low();
    check("t2_odd_parity", log_at(s + 9 * 4 + 2), 0);
    check("t2_odd_len", busy_run(s), 44);
    parity_en = 1'b0; parity_odd = 1'b0;

    // six bytes back-to-back through a 4-deep FIFO
    log_start();
    for (int k = 1; k <= 6; k++) push_byte(8'(k));
    wait_idle("t3");
    s = first_low();
    for (int k = 0; k < 6; k++) begin
      check("t3_start_bit", log_at(s + k * 40 + 2), 0);
      check("t3_byte_order", decode_byte(s + k * 40, 4), k + 1);
      check("t3_stop_bit", log_at(s + k * 40 + 36 + 2), 1);
    end
    check("t3_total_len", busy_run(s), 240);
    full_seen = 0; rdy_at_full = 0;
    foreach (cnt_log[k]) if (cnt_log[k] == 3'd4) begin
      full_seen++;
      if (rdy_log[k]) rdy_at_full++;
    end
    check("t3_full_reached", full_seen > 0, 1);
    check("t3_ready_low_when_full", rdy_at_full, 0);

    // two stop bits, stop2 dropped mid-frame: first gap 8, second frame 1 stop
    stop2 = 1'b1;
    log_start();
    push_byte(8'h00);
    push_byte(8'h00);
    wait_low("t4");
    repeat (10) @(negedge clk);
    stop2 = 1'b0;
    wait_idle("t4");
    s = first_low();
    check("t4_gap_high", busy_run(s) >= 0 ? (log_at(s + 35) == 1'b0) : 0, 1);
    begin
      int n = 0;
      for (int k = s + 36; k < line_log.size() && line_log[k]; k++) n++;
      check("t4_gap_len", n, 8);
    end
    check("t4_total_len", busy_run(s), 84);

    // baud_div = 1 and baud_div = 0 (default 1000/100 = 10)
    baud_div = 16'd1;
    log_start();
    push_byte(8'hA3);
    wait_idle("t5a");
    s = first_low();
    check("t5_div1_byte", decode_byte(s, 1), 8'hA3);
    check("t5_div1_len", busy_run(s), 10);
    baud_div = 16'd0;
    log_start();
    push_byte(8'h5A);
    wait_idle("t5b");
    s = first_low();
    check("t5_div0_byte", decode_byte(s, 10), 8'h5A);
    check("t5_div0_len", busy_run(s), 100);

    // reset during data bit 3, then a clean frame
    baud_div = 16'd4;
    push_byte(8'h00);
    push_byte(8'hA5);
    wait_low("t6");
    repeat (17) @(negedge clk);
    check("t6_pre_reset_low", serial_out, 0);
    check("t6_pre_reset_cnt", fifo_count, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_serial_out", serial_out, 1);
    check("t6_rst_fifo_count", fifo_count, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", data_in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_post_idle", busy, 0);
    log_start();
    push_byte(8'h3C);
    wait_idle("t6");
    s = first_low();
    check("t6_clean_byte", decode_byte(s, 4), 8'h3C);
    check("t6_clean_len", busy_run(s), 40);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Configurable UART serial transmitter, the next generation of the single-byte TX.
- Adds a parametrised input FIFO and a runtime baud divisor.
- Adds runtime-selectable parity (none/even/odd) and stop bits (1 or 2).
- Sits between the MMIO/UART register block (byte writes) and the serial TX pin.
- Sends LSB-first 8N1-style frames back-to-back with no idle gap while the FIFO holds data.

Parameters:
- CLOCK_FREQ, 125_000_000, system clock in Hz.
- BAUD_RATE, 115_200, default baud, used when baud_div == 0.
- DATA_WIDTH, 8, data bits per frame (5..8).
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2.
- DIV_WIDTH, 16, width of runtime divisor.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  byte to transmit.
- data_in_valid  input  1  producer has a byte.
- data_in_ready  output  1  FIFO not full; push when valid && ready.
- baud_div  input  DIV_WIDTH  clocks per bit; 0 selects CLOCK_FREQ/BAUD_RATE.
- parity_en  input  1  append parity bit.
- parity_odd  input  1  1 = odd parity, 0 = even.
- stop2  input  1  1 = two stop bits.
- serial_out  output  1  TX line, idle high, registered.
- busy  output  1  frame in progress or FIFO non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high. While reset is high:
  - serial_out=1, data_in_ready=1, busy=0, fifo_count=0.
  - FSM goes to IDLE, counters go to 0, FIFO is emptied.
- Reset mid-frame aborts the frame immediately. The line returns high asynchronously and no partial frame resumes.
- FIFO push: occurs on a clk edge when data_in_valid && data_in_ready.
  - data_in_ready = (fifo_count < FIFO_DEPTH).
  - When full, a push is refused even if a pop happens in the same cycle.
  - No bypass: a byte written into an empty FIFO is popped on the following edge at the earliest.
- Bit period P:
  - P = baud_div when baud_div != 0; baud_div=1 gives 1 clock per bit.
  - P = CLOCK_FREQ/BAUD_RATE when baud_div == 0.
  - baud_div, parity_en, parity_odd and stop2 are sampled into a frame-config register at the pop. Changes mid-frame take effect on the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if fifo_count != 0, pop the head into the shift register, latch config, go to START.
  - START: serial_out=0 for P clocks, then go to DATA.
  - DATA: shift LSB first, DATA_WIDTH bits, each held P clocks. Then go to PARITY if parity_en, else STOP.
  - PARITY: send XOR of the data bits; inverted if parity_odd. Hold P clocks.
  - STOP: serial_out=1 for P clocks, or 2P clocks if stop2.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START, so the next start bit follows the last stop bit with zero gap. Otherwise go to IDLE.
- Latency: a push at edge N into an empty, idle block gives a pop at edge N+1, and serial_out falls after edge N+1.
- Frame length: (1 + DATA_WIDTH + parity_en + 1 + stop2) * P clocks.
- busy = (state != IDLE) || (fifo_count != 0). Registered-consistent with state; busy falls with the return to IDLE.
- Bit counter: 4 bits, terminal count DATA_WIDTH-1. Baud counter: DIV_WIDTH bits, terminal count P-1, cleared on each state entry.
- serial_out is a flop output, glitch-free.

Decomposition:
- Package uart_pkg holds:
  - the tx_state enum (IDLE, START, DATA, PARITY, STOP);
  - localparam DEFAULT_DIV = CLOCK_FREQ/BAUD_RATE, computed in-module from parameters;
  - the frame-config struct (div, parity_en, parity_odd, stop2).
- One sub-module, uart_sync_fifo: parametrised DEPTH/WIDTH synchronous FIFO with count output, async active-high reset. It is reusable by a future RX block.

Test Plan:
All scenarios use DATA_WIDTH=8, FIFO_DEPTH=4, baud_div=4 unless stated.
- Push 0x55, no parity, 1 stop -> serial_out = 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks (40 clocks total). busy falls after the last stop bit.
- Parity: 0x07 with parity_en=1, even -> parity bit 1. Same byte with parity_odd=1 -> parity bit 0. Frame is 44 clocks.
- Push 6 bytes back-to-back (0x01..0x06):
  - data_in_ready drops when fifo_count=4 and rises after the next pop;
  - all 6 frames arrive contiguously with no idle between stop and start;
  - bytes arrive in order.
- stop2=1, two bytes -> line high exactly 8 clocks between frames. Toggling stop2 mid-frame does not change the current frame.
- baud_div=1 -> 1 clock per bit, 10-clock frame. baud_div=0 with CLOCK_FREQ=1000, BAUD_RATE=100 -> 10 clocks per bit.
- Assert reset during DATA bit 3 -> serial_out=1 immediately, fifo_count=0, busy=0. A new push after release gives a clean full frame.
